// File: rtl/usb_uart_cmd_bridge.sv
// Command bridge: parses framed R/W commands from the USB UART byte stream, runs one register-bus access, streams the reply back.
// Optional inter-byte idle abort is compiled in with `define BRIDGE_RX_TIMEOUT_EN.
module usb_uart_cmd_bridge #(
  parameter int unsigned ADDR_BYTES  = 2,
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned BUS_TIMEOUT = 1024,
  parameter int unsigned RX_TIMEOUT  = 48000
) (
  input  logic                    clk_48mhz,
  input  logic                    reset,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  output logic                    rx_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [8*DATA_BYTES-1:0] bus_wdata,
  input  logic [8*DATA_BYTES-1:0] bus_rdata,
  input  logic                    bus_ack
);

  localparam int unsigned AW   = 8 * ADDR_BYTES;
  localparam int unsigned DW   = 8 * DATA_BYTES;
  localparam int unsigned MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned BCW  = $clog2(MAXB + 1);
  localparam int unsigned TOW  = $clog2(BUS_TIMEOUT + 1);

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] RSP_K = 8'h4B;
  localparam logic [7:0] RSP_E = 8'h45;
  localparam logic [7:0] RSP_T = 8'h54;

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] GET_ADDR = 3'd1;
  localparam logic [2:0] GET_DATA = 3'd2;
  localparam logic [2:0] BUS      = 3'd3;
  localparam logic [2:0] SEND     = 3'd4;

  logic [2:0]     state, state_nxt;
  logic [BCW-1:0] byte_cnt, byte_cnt_nxt;
  logic [TOW-1:0] to_cnt, to_cnt_nxt;
  logic [DW-1:0]  resp, resp_nxt;
  logic [7:0]     tx_data_nxt;
  logic           rx_ready_nxt, tx_valid_nxt, bus_req_nxt, bus_we_nxt;
  logic [AW-1:0]  bus_addr_nxt;
  logic [DW-1:0]  bus_wdata_nxt;
  logic           rx_byte, tx_done;

`ifdef BRIDGE_RX_TIMEOUT_EN
  localparam int unsigned RIW = $clog2(RX_TIMEOUT + 1);
  logic [RIW-1:0] rx_idle, rx_idle_nxt;
`endif

  assign rx_byte = rx_valid && rx_ready;
  assign tx_done = tx_valid && tx_ready;

  // State and registered outputs
  always_ff @(posedge clk_48mhz or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      to_cnt    <= '0;
      resp      <= '0;
      rx_ready  <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
`ifdef BRIDGE_RX_TIMEOUT_EN
      rx_idle   <= '0;
`endif
    end else begin
      state     <= state_nxt;
      byte_cnt  <= byte_cnt_nxt;
      to_cnt    <= to_cnt_nxt;
      resp      <= resp_nxt;
      rx_ready  <= rx_ready_nxt;
      tx_valid  <= tx_valid_nxt;
      tx_data   <= tx_data_nxt;
      bus_req   <= bus_req_nxt;
      bus_we    <= bus_we_nxt;
      bus_addr  <= bus_addr_nxt;
      bus_wdata <= bus_wdata_nxt;
`ifdef BRIDGE_RX_TIMEOUT_EN
      rx_idle   <= rx_idle_nxt;
`endif
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt     = state;
    byte_cnt_nxt  = byte_cnt;
    to_cnt_nxt    = to_cnt;
    resp_nxt      = resp;
    tx_data_nxt   = tx_data;
    bus_we_nxt    = bus_we;
    bus_addr_nxt  = bus_addr;
    bus_wdata_nxt = bus_wdata;
`ifdef BRIDGE_RX_TIMEOUT_EN
    rx_idle_nxt   = '0;
`endif

    case (state)
      IDLE: begin
        if (rx_byte) begin
          if (rx_data == CMD_W || rx_data == CMD_R) begin
            state_nxt     = GET_ADDR;
            bus_we_nxt    = (rx_data == CMD_W);
            bus_addr_nxt  = '0;
            bus_wdata_nxt = '0;
            byte_cnt_nxt  = '0;
          end else begin
            state_nxt    = SEND;
            tx_data_nxt  = RSP_E;
            byte_cnt_nxt = '0;
          end
        end
      end
      GET_ADDR: begin
        if (rx_byte) begin
          bus_addr_nxt = (bus_addr << 8) | AW'(rx_data);
          if (byte_cnt == BCW'(ADDR_BYTES - 1)) begin
            byte_cnt_nxt = '0;
            to_cnt_nxt   = '0;
            state_nxt    = bus_we ? GET_DATA : BUS;
          end else begin
            byte_cnt_nxt = byte_cnt + 1'b1;
          end
        end
      end
      GET_DATA: begin
        if (rx_byte) begin
          bus_wdata_nxt = (bus_wdata << 8) | DW'(rx_data);
          if (byte_cnt == BCW'(DATA_BYTES - 1)) begin
            byte_cnt_nxt = '0;
            to_cnt_nxt   = '0;
            state_nxt    = BUS;
          end else begin
            byte_cnt_nxt = byte_cnt + 1'b1;
          end
        end
      end
      BUS: begin
        // ack beats a timeout landing on the same cycle
        if (bus_ack) begin
          state_nxt = SEND;
          if (bus_we) begin
            tx_data_nxt  = RSP_K;
            byte_cnt_nxt = '0;
          end else begin
            tx_data_nxt  = bus_rdata[DW-1 -: 8];
            resp_nxt     = bus_rdata << 8;
            byte_cnt_nxt = BCW'(DATA_BYTES - 1);
          end
        end else if (to_cnt == TOW'(BUS_TIMEOUT - 1)) begin
          state_nxt    = SEND;
          tx_data_nxt  = RSP_T;
          byte_cnt_nxt = '0;
        end else begin
          to_cnt_nxt = to_cnt + 1'b1;
        end
      end
      SEND: begin
        // byte_cnt holds the number of bytes still to follow the current one
        if (tx_done) begin
          if (byte_cnt == '0) begin
            state_nxt = IDLE;
          end else begin
            tx_data_nxt  = resp[DW-1 -: 8];
            resp_nxt     = resp << 8;
            byte_cnt_nxt = byte_cnt - 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

`ifdef BRIDGE_RX_TIMEOUT_EN
    // Abandon a stalled partial frame silently
    if ((state == GET_ADDR || state == GET_DATA) && !rx_byte) begin
      if (rx_idle == RIW'(RX_TIMEOUT - 1)) begin
        state_nxt    = IDLE;
        byte_cnt_nxt = '0;
      end else begin
        rx_idle_nxt = rx_idle + 1'b1;
      end
    end
`endif

    rx_ready_nxt = (state_nxt == IDLE) || (state_nxt == GET_ADDR) || (state_nxt == GET_DATA);
    tx_valid_nxt = (state_nxt == SEND);
    bus_req_nxt  = (state_nxt == BUS);
  end

endmodule

// File: tb/tb_usb_uart_cmd_bridge.sv
// Scoreboard bench for usb_uart_cmd_bridge: expected bus accesses and response bytes are queued by the stimulus and checked by monitors.
module tb_usb_uart_cmd_bridge;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        bus_req;
  logic        bus_we;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'h0;
  logic        bus_ack = 1'b0;

  int total = 0;
  int bad = 0;

  logic [7:0] tx_q[$];
  acc_t       acc_q[$];

  int          ack_delay = 0;
  logic [31:0] rd_val = 32'h0;
  int          req_len = 0;

  usb_uart_cmd_bridge dut (
    .clk_48mhz(clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus_req  (bus_req),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ack  (bus_ack)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus slave: acks after ack_delay bus_req cycles (negative = never)
  initial begin
    int  cyc = 0;
    bit  done = 0;
    forever begin
      @(negedge clk);
      if (bus_req && !reset && !done) begin
        if (ack_delay >= 0 && cyc == ack_delay) begin
          bus_ack   = 1'b1;
          bus_rdata = rd_val;
          done      = 1;
        end else begin
          bus_ack = 1'b0;
        end
        cyc++;
      end else begin
        bus_ack = 1'b0;
        if (!bus_req || reset) begin
          cyc  = 0;
          done = 0;
        end
      end
    end
  end

  // Response monitor: pops on each accepted byte, checks hold under backpressure
  initial begin
    bit         stalled = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        stalled = 0;
      end else if (tx_valid) begin
        if (stalled) check("tx_data_hold", 64'(tx_data), 64'(held));
        stalled = !tx_ready;
        held    = tx_data;
        if (tx_ready) begin
          if (tx_q.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got %0h expected none", tx_data);
          end else begin
            e = tx_q.pop_front();
            check("tx_byte", 64'(tx_data), 64'(e));
          end
        end
      end else begin
        if (stalled) check("tx_valid_hold", 64'(tx_valid), 64'd1);
        stalled = 0;
      end
    end
  end

  // Access monitor: pops on each bus_req rise, records request length
  initial begin
    bit   prev = 0;
    int   cnt = 0;
    acc_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        prev = 0;
        cnt  = 0;
      end else begin
        if (bus_req && !prev) begin
          if (acc_q.size() == 0) begin
            total++; bad++;
            $display("FAIL acc_unexpected: got addr %0h expected none", bus_addr);
          end else begin
            e = acc_q.pop_front();
            check("acc_we", 64'(bus_we), 64'(e.we));
            check("acc_addr", 64'(bus_addr), 64'(e.addr));
            check("acc_wdata", 64'(bus_wdata), 64'(e.wdata));
          end
        end
        if (bus_req) begin
          cnt++;
        end else begin
          if (prev) req_len = cnt;
          cnt = 0;
        end
        prev = bus_req;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) check("rx_accept_timeout", 64'(rx_ready), 64'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      #3;
      if (tx_q.size() == 0 && acc_q.size() == 0 && rx_ready && !tx_valid && !bus_req) break;
      n++;
      if (n > 3000) begin
        check(name, 64'(tx_q.size() + acc_q.size()), 64'd0);
        tx_q.delete();
        acc_q.delete();
        break;
      end
    end
  endtask

  initial begin
    int n;
    #1;
    check("rst_outputs", {tx_data, rx_ready, tx_valid, bus_req, bus_we, bus_addr, bus_wdata}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1 check("rst_rx_ready_low", 64'(rx_ready), 64'd0);
    @(negedge clk);
    check("rst_rx_ready_rise", 64'(rx_ready), 64'd1);

    // Write with ack after 3 cycles
    ack_delay = 3;
    acc_q.push_back('{we: 1'b1, addr: 16'h0010, wdata: 32'hDEADBEEF});
    tx_q.push_back(8'h4B);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h10);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    check("wr_req_latency", 64'(bus_req), 64'd1);
    wait_done("wr_done");
    check("wr_req_len", 64'(req_len), 64'd4);

    // Read with immediate ack
    ack_delay = 0;
    rd_val = 32'h01020304;
    acc_q.push_back('{we: 1'b0, addr: 16'h1234, wdata: 32'h0});
    tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03); tx_q.push_back(8'h04);
    send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
    wait_done("rd_done");
    check("rd_req_len", 64'(req_len), 64'd1);

    // Unknown command
    tx_q.push_back(8'h45);
    send_byte(8'h41);
    check("unk_latency", 64'(tx_valid), 64'd1);
    wait_done("unk_done");

    // Bus timeout
    ack_delay = -1;
    acc_q.push_back('{we: 1'b0, addr: 16'h0000, wdata: 32'h0});
    tx_q.push_back(8'h54);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
    wait_done("to_done");
    check("to_req_len", 64'(req_len), 64'd1024);

    // Ack on the final timeout cycle still gives data
    ack_delay = 1023;
    rd_val = 32'h0A0B0C0D;
    acc_q.push_back('{we: 1'b0, addr: 16'h0005, wdata: 32'h0});
    tx_q.push_back(8'h0A); tx_q.push_back(8'h0B); tx_q.push_back(8'h0C); tx_q.push_back(8'h0D);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h05);
    wait_done("late_ack_done");
    check("late_ack_req_len", 64'(req_len), 64'd1024);

    // Backpressure with rx_valid held high throughout
    ack_delay = 1;
    rd_val = 32'hA1B2C3D4;
    tx_ready = 1'b0;
    acc_q.push_back('{we: 1'b0, addr: 16'h0040, wdata: 32'h0});
    tx_q.push_back(8'hA1); tx_q.push_back(8'hB2); tx_q.push_back(8'hC3); tx_q.push_back(8'hD4);
    tx_q.push_back(8'h45);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h40);
    rx_data  = 8'h41;
    rx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && n < 100);
    check("bp_tx_valid", 64'(tx_valid), 64'd1);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (c == 19) check("bp_rx_ready_low", 64'(rx_ready), 64'd0);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      check("bp_rx_ready_after_byte", 64'(rx_ready), (k == 3) ? 64'd1 : 64'd0);
    end
    tx_ready = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    wait_done("bp_done");

`ifdef BRIDGE_RX_TIMEOUT_EN
    // Stalled partial frame is dropped, next frame runs
    ack_delay = 0;
    rd_val = 32'h11223344;
    send_byte(8'h57); send_byte(8'h00);
    repeat (48010) @(negedge clk);
    acc_q.push_back('{we: 1'b0, addr: 16'h0001, wdata: 32'h0});
    tx_q.push_back(8'h11); tx_q.push_back(8'h22); tx_q.push_back(8'h33); tx_q.push_back(8'h44);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    wait_done("rxto_done");
`else
    // Without idle abort the bytes continue the pending write frame
    ack_delay = 0;
    send_byte(8'h57); send_byte(8'h00);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h01);
    repeat (50) @(negedge clk);
    check("partial_no_req", 64'(bus_req), 64'd0);
    check("partial_rx_ready", 64'(rx_ready), 64'd1);
    acc_q.push_back('{we: 1'b1, addr: 16'h0052, wdata: 32'h0001AABB});
    tx_q.push_back(8'h4B);
    send_byte(8'hAA); send_byte(8'hBB);
    wait_done("partial_done");
`endif

    // Reset while the access is outstanding
    ack_delay = -1;
    acc_q.push_back('{we: 1'b0, addr: 16'h0008, wdata: 32'h0});
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h08);
    n = 0;
    while (!bus_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check("midbus_req_high", 64'(bus_req), 64'd1);
    #3 reset = 1'b1;
    #1 check("midbus_rst_outputs", {tx_data, rx_ready, tx_valid, bus_req, bus_we, bus_addr, bus_wdata}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    acc_q.delete();
    ack_delay = 2;
    rd_val = 32'hCAFEF00D;
    acc_q.push_back('{we: 1'b0, addr: 16'h000C, wdata: 32'h0});
    tx_q.push_back(8'hCA); tx_q.push_back(8'hFE); tx_q.push_back(8'hF0); tx_q.push_back(8'h0D);
    send_byte(8'h52); send_byte(8'h00); send_byte(8'h0C);
    wait_done("post_rst_done");
    check("post_rst_req_len", 64'(req_len), 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_uart_cmd_bridge.md
# usb_uart_cmd_bridge

Device-side responder on the byte pipeline of the USB serial function. It consumes host-to-device bytes (the USB UART's `uart_out_*` stream) and parses framed read/write commands. It executes each command as one access on a simple register bus, then returns a response byte stream into the USB UART's `uart_in_*` input. It sits between the USB serial endpoint and the system's peripheral register space.

## Interface
Parameters:
- ADDR_BYTES, 2, address bytes per command; bus_addr width = 8*ADDR_BYTES
- DATA_BYTES, 4, data bytes per access; bus data width = 8*DATA_BYTES
- BUS_TIMEOUT, 1024, cycles to wait for bus_ack before aborting (≥1)
- RX_TIMEOUT, 48000, inter-byte idle limit mid-command (used only with BRIDGE_RX_TIMEOUT_EN)

Ports:
- clk_48mhz  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- rx_data  in  8  command byte, from USB UART uart_out_data
- rx_valid  in  1  rx_data valid, from uart_out_valid
- rx_ready  out  1  bridge accepts byte, to uart_out_ready
- tx_data  out  8  response byte, to uart_in_data
- tx_valid  out  1  tx_data valid, to uart_in_valid
- tx_ready  in  1  USB UART accepts byte, from uart_in_ready
- bus_req  out  1  access request, held until ack or timeout
- bus_we  out  1  1 = write, 0 = read; valid while bus_req
- bus_addr  out  8*ADDR_BYTES  access address
- bus_wdata  out  8*DATA_BYTES  write data
- bus_rdata  in  8*DATA_BYTES  read data, sampled on the bus_ack cycle
- bus_ack  in  1  single-cycle completion strobe

## Operation
- Frame format: command byte, then ADDR_BYTES address bytes MSB first. A write frame then carries DATA_BYTES data bytes, MSB first.
  - 0x57 ('W'): write. Response is 0x4B ('K').
  - 0x52 ('R'): read. Response is DATA_BYTES bytes of bus_rdata, MSB first.
  - Any other command byte: respond 0x45 ('E') immediately. No address bytes are consumed.
- Bus timeout: respond with the single byte 0x54 ('T') instead of the normal response, for both read and write.
- States:
  - IDLE: rx_ready=1. An accepted byte is decoded: 'W'/'R' → GET_ADDR; other → SEND with 'E'.
  - GET_ADDR: rx_ready=1. Shift bytes into bus_addr. After the ADDR_BYTES-th byte: write → GET_DATA; read → BUS.
  - GET_DATA: rx_ready=1. Shift bytes into bus_wdata. After the DATA_BYTES-th byte → BUS.
  - BUS: bus_req=1, and bus_we/bus_addr/bus_wdata are stable.
    - bus_ack → capture rdata, go to SEND.
    - BUS_TIMEOUT cycles without ack → SEND with 'T'.
  - SEND: rx_ready=0, tx_valid=1. Each tx_valid&&tx_ready advances to the next byte. After the last byte is accepted → IDLE.
- rx_ready is 0 in BUS and SEND. A byte is consumed only on rx_valid&&rx_ready.
- bus_ack outside BUS is ignored.
- The address/data shift registers clear on entry to GET_ADDR. A short frame therefore never mixes in stale bytes.
- Reset mid-operation abandons the frame and the access; the bus_req drop is the only indication to the bus.

## Timing
- Reset values:
  - rx_ready=0, tx_valid=0, tx_data=0x00
  - bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0
  - state IDLE
- rx_ready rises the first cycle after reset deasserts.
- bus_req asserts the cycle after the final frame byte is accepted.
- bus_req deasserts the cycle after the bus_ack cycle; bus_ack in the first bus_req cycle is legal.
- Timeout counter:
  - Starts at 0 with bus_req.
  - 'T' is selected when the count reaches BUS_TIMEOUT with no ack.
  - An ack arriving on the same cycle as the timeout wins: normal response.
- Response latency: tx_valid asserts the cycle after bus_ack, or one cycle after an unknown command byte is accepted.
- tx_data is held stable and tx_valid is held high until tx_ready; tx_valid never drops before acceptance.
- IDLE re-entry: rx_ready=1 on the cycle after the last response byte is accepted.

## Configuration
- Macro: BRIDGE_RX_TIMEOUT_EN.
- Defined:
  - An inter-byte counter runs in GET_ADDR/GET_DATA. It clears on each accepted byte and on entry to those states.
  - When the count reaches RX_TIMEOUT, the bridge returns to IDLE silently. The partial frame is discarded, with no response and no bus access.
- Undefined: the counter logic is absent, RX_TIMEOUT is unused, and the bridge waits indefinitely for the remaining frame bytes.

## Test plan
- Write: send 57 00 10 DE AD BE EF, bus acks after 3 cycles → one access with bus_we=1, bus_addr=0x0010, bus_wdata=0xDEADBEEF; response 4B.
- Read: send 52 12 34, bus_rdata=0x01020304, ack after 0 cycles → bus_we=0, bus_addr=0x1234; response 01 02 03 04 in that order.
- Unknown/timeout: send 41 → response 45, no bus_req. Send 52 00 00 with no ack → bus_req high exactly 1024 cycles; response 54. Ack on cycle 1024 → data response.
- Backpressure: read with tx_ready held low 20 cycles between bytes and rx_valid asserted throughout → tx_data stable while stalled, rx_ready=0 until the 4th byte is accepted.
- RX timeout (macro defined): send 57 00, idle 48000 cycles, then send 52 00 01 → no access for the first frame; read at 0x0001 completes. Macro undefined: the same stimulus yields a write to 0x0052 with wdata 0x0001xxxx pending (frame still incomplete).
- Reset mid-BUS: assert reset while bus_req=1 → all outputs at reset values immediately; a following 'R' frame is processed normally.
